mdu: RTL and testbench

Multi-cycle multiply/divide unit in the EX stage, beside the ALU. It takes the same forwarded `a`/`b` operands the ALU sees and computes MIPS MULT/MULTU/DIV/DIVU into private HI/LO registers. MTHI/MTLO write those registers directly. The `busy` output drives the hazard unit's EX stall, and `hi`/`lo` feed the MFHI/MFLO leg of the EX result mux.

---
 rtl/mdu_pkg.sv | 24 ++
 rtl/mdu_negate.sv | 14 +
 rtl/mdu.sv | 158 +++++++++++++++
 tb/tb_mdu.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared op codes, FSM states and sizing helper for the multiply/divide unit.
// Optional single-cycle multiply is selected with MDU_FAST_MUL_EN in mdu.sv.
package mdu_pkg;

    localparam logic [2:0] MDU_MULT  = 3'b000;
    localparam logic [2:0] MDU_MULTU = 3'b001;
    localparam logic [2:0] MDU_DIV   = 3'b010;
    localparam logic [2:0] MDU_DIVU  = 3'b011;
    localparam logic [2:0] MDU_MTHI  = 3'b100;
    localparam logic [2:0] MDU_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } mdu_state_t;

    // Iteration counter must hold the value `w` itself.
    function automatic int mdu_cnt_w(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/mdu_negate.sv
// Conditional two's-complement negate: dout = en ? ~din + inc : din.
// Combinational, no backpressure; `inc` lets two instances chain into a wider negate.
module mdu_negate #(
    parameter int width = 32
) (
    input  logic             en,
    input  logic             inc,
    input  logic [width-1:0] din,
    output logic [width-1:0] dout
);

    assign dout = en ? (~din + {{(width-1){1'b0}}, inc}) : din;

endmodule

// File: rtl/mdu.sv
// Iterative MULT/MULTU/DIV/DIVU plus MTHI/MTLO into private HI/LO registers.
// Latency width+1 cycles (multiply 1 cycle with MDU_FAST_MUL_EN); busy stalls EX, start while busy is dropped.
module mdu
    import mdu_pkg::*;
#(
    parameter int width = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic             flush,
    input  logic [width-1:0] a,
    input  logic [width-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [width-1:0] hi,
    output logic [width-1:0] lo
);

    localparam int DW = 2 * width;
    localparam int CW = mdu_cnt_w(width);

    mdu_state_t       state_q, state_d;
    logic [DW-1:0]    acc_q;
    logic [width-1:0] opb_q;
    logic [CW-1:0]    cnt_q;
    logic             lo_neg_q, hi_neg_q, mul_q;

    logic             accept, is_signed, a_neg, b_neg, b_zero;
    logic [width-1:0] abs_a, abs_b;
    logic [width:0]   mul_sum;
    logic [DW-1:0]    mul_next, div_next;
    logic [width:0]   div_shift;
    logic             div_ge;
    logic [width-1:0] div_diff;
    logic [width-1:0] lo_fix, hi_fix;
    logic             hi_inc;

    assign accept    = (state_q == IDLE) && start && !flush;
    assign is_signed = (op == MDU_MULT) || (op == MDU_DIV);
    assign a_neg     = is_signed && a[width-1];
    assign b_neg     = is_signed && b[width-1];
    assign b_zero    = (b == '0);

    mdu_negate #(.width(width)) u_abs_a (.en(a_neg), .inc(1'b1), .din(a), .dout(abs_a));
    mdu_negate #(.width(width)) u_abs_b (.en(b_neg), .inc(1'b1), .din(b), .dout(abs_b));

    // Shift-add: multiplier sits in the low half and is consumed LSB first.
    assign mul_sum  = {1'b0, acc_q[DW-1:width]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    assign mul_next = {mul_sum, acc_q[width-1:1]};

    // Restoring divide: upper half is the remainder, lower half shifts dividend out and quotient in.
    assign div_shift = {acc_q[DW-1:width], acc_q[width-1]};
    assign div_ge    = (div_shift >= {1'b0, opb_q});
    assign div_diff  = div_shift[width-1:0] - opb_q;
    assign div_next  = {(div_ge ? div_diff : div_shift[width-1:0]), acc_q[width-2:0], div_ge};

    // A 2*width product negate borrows into HI only when LO is zero.
    assign hi_inc = mul_q ? (acc_q[width-1:0] == '0) : 1'b1;

    mdu_negate #(.width(width)) u_fix_lo (
        .en(lo_neg_q), .inc(1'b1), .din(acc_q[width-1:0]), .dout(lo_fix)
    );
    mdu_negate #(.width(width)) u_fix_hi (
        .en(hi_neg_q), .inc(hi_inc), .din(acc_q[DW-1:width]), .dout(hi_fix)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    case (op)
`ifdef MDU_FAST_MUL_EN
                        MDU_MULT, MDU_MULTU: state_d = FIX;
`else
                        MDU_MULT, MDU_MULTU: state_d = MUL;
`endif
                        MDU_DIV, MDU_DIVU:   state_d = DIV;
                        default:             state_d = IDLE;
                    endcase
                end
            end
            MUL, DIV: begin
                if (cnt_q == CW'(1))
                    state_d = FIX;
            end
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush)
            state_d = IDLE;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
            cnt_q    <= '0;
            lo_neg_q <= 1'b0;
            hi_neg_q <= 1'b0;
            mul_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            busy    <= (state_d != IDLE);
            done    <= (state_q == FIX) && !flush;

            if (accept) begin
                case (op)
                    MDU_MTHI: hi <= a;
                    MDU_MTLO: lo <= a;
                    MDU_MULT, MDU_MULTU: begin
`ifdef MDU_FAST_MUL_EN
                        acc_q <= {{width{1'b0}}, abs_a} * {{width{1'b0}}, abs_b};
`else
                        acc_q <= {{width{1'b0}}, abs_b};
`endif
                        opb_q    <= abs_a;
                        cnt_q    <= CW'(width);
                        lo_neg_q <= a_neg ^ b_neg;
                        hi_neg_q <= a_neg ^ b_neg;
                        mul_q    <= 1'b1;
                    end
                    MDU_DIV, MDU_DIVU: begin
                        acc_q    <= {{width{1'b0}}, abs_a};
                        opb_q    <= abs_b;
                        cnt_q    <= CW'(width);
                        // Divide by zero yields quotient all ones and remainder |a|; re-signing gives back a.
                        lo_neg_q <= !b_zero && (a_neg ^ b_neg);
                        hi_neg_q <= a_neg;
                        mul_q    <= 1'b0;
                    end
                    default: ;
                endcase
            end

            if (state_q == MUL) begin
                acc_q <= mul_next;
                cnt_q <= cnt_q - CW'(1);
            end else if (state_q == DIV) begin
                acc_q <= div_next;
                cnt_q <= cnt_q - CW'(1);
            end

            if (state_q == FIX && !flush) begin
                hi <= hi_fix;
                lo <= lo_fix;
            end
        end
    end

endmodule

// File: tb/tb_mdu.sv
// Random and directed checks of mdu against a plain-arithmetic HI/LO model.
// Honours MDU_FAST_MUL_EN for expected multiply latency.
module tb_mdu;
    import mdu_pkg::*;

    localparam int W = 32;
`ifdef MDU_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = W + 1;
`endif
    localparam int DIV_LAT = W + 1;

    logic         clock = 1'b0;
    logic         reset_n, start, flush;
    logic [2:0]   op;
    logic [W-1:0] a, b;
    logic         busy, done;
    logic [W-1:0] hi, lo;

    logic [W-1:0] m_hi, m_lo;
    int n_chk  = 0;
    int n_pass = 0;

    mdu #(.width(W)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .op(op), .flush(flush),
        .a(a), .b(b), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         output logic [W-1:0] eh, output logic [W-1:0] el);
        longint sx, sy, q, r;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        eh = m_hi;
        el = m_lo;
        case (o)
            MDU_MULT:  begin p = 64'(sx * sy); {eh, el} = p; end
            MDU_MULTU: begin p = {32'b0, x} * {32'b0, y}; {eh, el} = p; end
            MDU_DIV, MDU_DIVU: begin
                if (y == 0) begin
                    el = '1; eh = x;
                end else if (o == MDU_DIVU) begin
                    el = x / y; eh = x % y;
                end else begin
                    q = sx / sy; r = sx % sy;
                    el = q[W-1:0]; eh = r[W-1:0];
                end
            end
            MDU_MTHI: eh = x;
            MDU_MTLO: el = x;
            default: ;
        endcase
    endtask

    // Called at a negedge with the unit idle (or in its done cycle); returns in the done cycle.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] eh, el;
        int lat;
        model(o, x, y, eh, el);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clock);
        start = 1'b0;
        check({tag, "_busy"}, 64'(busy), 64'd1);
        lat = 0;
        for (int k = 1; k <= 60 && lat == 0; k++) begin
            @(negedge clock);
            if (done) lat = k;
        end
        check({tag, "_lat"}, 64'(lat), 64'(o[1] ? DIV_LAT : MUL_LAT));
        check({tag, "_busy_in_done"}, 64'(busy), 64'd0);
        check({tag, "_hi"}, 64'(hi), 64'(eh));
        check({tag, "_lo"}, 64'(lo), 64'(el));
        m_hi = eh;
        m_lo = el;
    endtask

    initial begin
        int pulses;
        logic [W-1:0] ra, rb;
        logic [2:0] ro;
        reset_n = 1'b0; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
        m_hi = '0; m_lo = '0;
        repeat (3) @(negedge clock);
        check("rst_busy", 64'(busy), 0);
        check("rst_done", 64'(done), 0);
        check("rst_hi", 64'(hi), 0);
        check("rst_lo", 64'(lo), 0);
        reset_n = 1'b1;
        @(negedge clock);

        // Directed cases, each issued in the previous op's done cycle.
        run_op("mult",  MDU_MULT,  32'hFFFFFFFE, 32'd3);
        check("mult_hi_const", 64'(hi), 64'hFFFFFFFF);
        check("mult_lo_const", 64'(lo), 64'hFFFFFFFA);
        run_op("multu", MDU_MULTU, 32'hFFFFFFFE, 32'd3);
        check("multu_hi_const", 64'(hi), 64'h2);
        run_op("div",   MDU_DIV,   32'hFFFFFFF9, 32'd2);
        check("div_lo_const", 64'(lo), 64'hFFFFFFFD);
        check("div_hi_const", 64'(hi), 64'hFFFFFFFF);
        run_op("divu",  MDU_DIVU,  32'd7, 32'd2);
        run_op("divz",  MDU_DIVU,  32'h1234, 32'd0);
        check("divz_hi_const", 64'(hi), 64'h1234);
        run_op("sdivz", MDU_DIV,   32'hFFFFFF00, 32'd0);
        run_op("ovf",   MDU_DIV,   32'h80000000, 32'hFFFFFFFF);
        check("ovf_lo_const", 64'(lo), 64'h80000000);
        run_op("mneg0", MDU_MULT,  32'h80000000, 32'd0);
        run_op("mmin",  MDU_MULT,  32'h80000000, 32'h80000000);

        // MTLO: one edge, no busy, no done.
        @(negedge clock);
        start = 1'b1; op = MDU_MTLO; a = 32'h5A5A5A5A;
        @(negedge clock);
        start = 1'b0;
        check("mtlo_lo", 64'(lo), 64'h5A5A5A5A);
        pulses = 0;
        for (int k = 0; k < 3; k++) begin
            if (busy || done) pulses++;
            @(negedge clock);
        end
        check("mtlo_no_busy_done", 64'(pulses), 0);
        m_lo = 32'h5A5A5A5A;

        // MTHI while a divide is in flight is dropped.
        start = 1'b1; op = MDU_DIVU; a = 32'd1000; b = 32'd7;
        @(negedge clock);
        start = 1'b0;
        repeat (4) @(negedge clock);
        start = 1'b1; op = MDU_MTHI; a = 32'hDEADBEEF;
        @(negedge clock);
        start = 1'b0;
        check("mthi_busy_ignored", 64'(hi), 64'(m_hi));
        pulses = 0;
        for (int k = 0; k < 60 && pulses == 0; k++) begin
            @(negedge clock);
            if (done) pulses++;
        end
        check("mthi_busy_div_lo", 64'(lo), 64'd142);
        check("mthi_busy_div_hi", 64'(hi), 64'd6);
        m_hi = 32'd6; m_lo = 32'd142;

        // Flush at cycle 10 of a divide.
        @(negedge clock);
        start = 1'b1; op = MDU_DIV; a = 32'd12345; b = 32'd17;
        @(negedge clock);
        start = 1'b0;
        repeat (9) @(negedge clock);
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        check("flush_busy", 64'(busy), 0);
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            if (done || busy) pulses++;
            @(negedge clock);
        end
        check("flush_no_done", 64'(pulses), 0);
        check("flush_hi", 64'(hi), 64'(m_hi));
        check("flush_lo", 64'(lo), 64'(m_lo));

        // Flush beats a simultaneous start.
        start = 1'b1; flush = 1'b1; op = MDU_MTHI; a = 32'h0BADF00D;
        @(negedge clock);
        start = 1'b0; flush = 1'b0;
        check("flush_wins_hi", 64'(hi), 64'(m_hi));
        check("flush_wins_busy", 64'(busy), 0);

        // Randomised MULT/MULTU/DIV/DIVU, back-to-back.
        for (int i = 0; i < 24; i++) begin
            ro = 3'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            if (i % 6 == 1) rb = 32'($urandom_range(0, 3));
            if (i % 6 == 2) ra = 32'h80000000;
            if (i % 6 == 3) rb = 32'hFFFFFFFF;
            if (i % 6 == 4) rb = '0;
            run_op($sformatf("rnd%0d", i), ro, ra, rb);
        end

        // Asynchronous reset in the middle of a divide.
        start = 1'b1; op = MDU_DIV; a = 32'd99; b = 32'd5;
        @(negedge clock);
        start = 1'b0;
        repeat (5) @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        check("arst_busy", 64'(busy), 0);
        check("arst_done", 64'(done), 0);
        check("arst_hi", 64'(hi), 0);
        check("arst_lo", 64'(lo), 0);
        @(negedge clock);
        reset_n = 1'b1;
        m_hi = '0; m_lo = '0;
        @(negedge clock);
        check("arst_idle_busy", 64'(busy), 0);
        run_op("post_rst", MDU_DIV, 32'hFFFFFF9C, 32'd7);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
